booth_signed_divider: RTL and testbench
=======================================

Name: booth_signed_divider

Overview:
Sequential signed integer divider, the inverse of the Booth multiplier. It uses the same run/isValid handshake and operand/result style, so the two blocks can share a datapath controller.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands.
- Uses a radix-2 restoring algorithm on operand magnitudes, then a sign-correction step.
- Produces one quotient bit per clock.

Parameters:
WIDTH, 32, operand and result width in bits (minimum 4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
Dividend  input  WIDTH  signed dividend, sampled only on the start edge
Divisor  input  WIDTH  signed divisor, sampled only on the start edge
run  input  1  level start/hold request
busy  output  1  high while a division is in progress (CALC or FIX)
isValid  output  1  high while quotient/remainder hold a completed result (DONE)
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, sign equal to Dividend's (or zero)
divByZero  output  1  high with isValid when the captured Divisor was 0

Behaviour:
- Reset (async, any state): state=IDLE; busy, isValid, divByZero=0; quotient, remainder=0; counter and internal registers=0. An operation in progress is abandoned; no partial result is ever presented.
- States: IDLE, CALC, FIX, DONE.
- IDLE, run=1 at edge N:
  - Capture operands, sign flags sd=Dividend[MSB] and sq=Dividend[MSB]^Divisor[MSB].
  - Capture magnitudes |Dividend| and |Divisor| as unsigned WIDTH-bit values. |-2^(WIDTH-1)| = 2^(WIDTH-1), exactly representable.
  - Divisor!=0: go to CALC, counter=0, busy=1.
  - Divisor==0: go directly to DONE after edge N. Outputs quotient=all ones (-1), remainder=Dividend, divByZero=1, isValid=1, busy=0.
- IDLE, run=0: no change; outputs keep the last result.
- CALC, one iteration per edge:
  - Partial remainder P (WIDTH+1 bits) and Q register.
  - {P,Q} shifts left 1. T = P - |Divisor|.
  - If T>=0: P=T, Q[0]=1. Otherwise P is unchanged and Q[0]=0.
  - Counter increments. The edge performing iteration WIDTH-1 moves to FIX.
- FIX, one edge:
  - quotient = sq ? -Q : Q.
  - remainder = sd ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - isValid=1, busy=0, divByZero=0. Go to DONE.
- Latency: start edge N, CALC edges N+1..N+WIDTH, FIX edge N+WIDTH+1. isValid is visible after edge N+WIDTH+1 (N+33 for WIDTH=32).
- DONE:
  - Outputs hold while run=1; a held run never restarts an operation.
  - run=0 at an edge: go to IDLE, isValid=0, divByZero=0; quotient/remainder retained.
  - A new operation requires run low for at least one edge, then high.
- Changes on run, Dividend or Divisor during CALC/FIX are ignored. Dropping run mid-operation does not abort it. If run is already low on entering DONE, isValid is high for exactly one cycle.
- Overflow: -2^(WIDTH-1) / -1 gives quotient=0x80000000 (wraps), remainder=0, no flag.
- All outputs are registered; no combinational path from inputs to outputs.
- Arithmetic identity for every non-zero divisor: Dividend == quotient*Divisor + remainder (mod 2^WIDTH), with |remainder| < |Divisor|.

Test Plan:
1. Reset, then Dividend=28, Divisor=-5, run=1 held -> isValid after 33 edges; quotient=-5 (0xFFFFFFFB), remainder=3; busy=1 during edges 1..33.
2. Dividend=-7, Divisor=2 -> quotient=-3, remainder=-1. Dividend=4, Divisor=-7 -> quotient=0, remainder=4.
3. Dividend=100, Divisor=0 -> isValid and divByZero after 1 edge; quotient=0xFFFFFFFF, remainder=100.
4. Dividend=0x80000000, Divisor=-1 -> quotient=0x80000000, remainder=0. Dividend=0x80000000, Divisor=0x80000000 -> quotient=1, remainder=0.
5. Handshake:
   - Hold run high 400 ns after completion: isValid stays 1 and no restart.
   - Drop run, then raise it with new operands 9/3: second result quotient=3, remainder=0.
   - Toggle operands during CALC: result unchanged.
6. Assert rst at iteration 10 of a division -> all outputs 0 immediately (async), state IDLE. Release rst and rerun 28/-5 -> correct result after 33 edges.

Source files
------------

// File: rtl/booth_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : booth_signed_divider
// Purpose  : Sequential signed divider. Radix-2 restoring division on operand
//            magnitudes, one quotient bit per clock, then a sign-correction
//            step. Shares the run/isValid handshake of the Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module booth_signed_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             run,
  output logic             busy,
  output logic             isValid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [WIDTH:0]     r_p,     w_p_nxt;      // partial remainder
  logic [WIDTH-1:0]   r_q,     w_q_nxt;      // quotient magnitude / shifted dividend
  logic [WIDTH-1:0]   r_dvs,   w_dvs_nxt;    // divisor magnitude
  logic               r_sd,    w_sd_nxt;     // remainder sign (dividend sign)
  logic               r_sq,    w_sq_nxt;     // quotient sign
  logic               r_busy,  w_busy_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_dbz,   w_dbz_nxt;
  logic [WIDTH-1:0]   r_quot,  w_quot_nxt;
  logic [WIDTH-1:0]   r_rem,   w_rem_nxt;

  // Trial subtraction is done one bit wider than P so its sign bit tells
  // whether the shifted partial remainder was at least the divisor.
  logic [WIDTH+1:0]   w_trial;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;

  assign w_trial   = {r_p, r_q[WIDTH-1]} - {2'b00, r_dvs};
  // Negating the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
  assign w_dvd_mag = Dividend[WIDTH-1] ? (-Dividend) : Dividend;
  assign w_dvs_mag = Divisor[WIDTH-1]  ? (-Divisor)  : Divisor;

  assign busy      = r_busy;
  assign isValid   = r_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign divByZero = r_dbz;

  // State and datapath registers; async reset abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_dvs   <= '0;
      r_sd    <= 1'b0;
      r_sq    <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_p     <= w_p_nxt;
      r_q     <= w_q_nxt;
      r_dvs   <= w_dvs_nxt;
      r_sd    <= w_sd_nxt;
      r_sq    <= w_sq_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_dbz   <= w_dbz_nxt;
      r_quot  <= w_quot_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_p_nxt     = r_p;
    w_q_nxt     = r_q;
    w_dvs_nxt   = r_dvs;
    w_sd_nxt    = r_sd;
    w_sq_nxt    = r_sq;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    w_dbz_nxt   = r_dbz;
    w_quot_nxt  = r_quot;
    w_rem_nxt   = r_rem;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_sd_nxt  = Dividend[WIDTH-1];
          w_sq_nxt  = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
          w_q_nxt   = w_dvd_mag;
          w_p_nxt   = '0;
          w_dvs_nxt = w_dvs_mag;
          w_cnt_nxt = '0;
          if (Divisor == '0) begin
            w_quot_nxt  = '1;
            w_rem_nxt   = Dividend;
            w_dbz_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!w_trial[WIDTH+1]) begin
          w_p_nxt = w_trial[WIDTH:0];
          w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
        end else begin
          w_p_nxt = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
          w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == C_LAST) begin
          w_state_nxt = S_FIX;
        end
      end

      S_FIX: begin
        w_quot_nxt  = r_sq ? (-r_q) : r_q;
        w_rem_nxt   = r_sd ? (-r_p[WIDTH-1:0]) : r_p[WIDTH-1:0];
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_dbz_nxt   = 1'b0;
        w_state_nxt = S_DONE;
      end

      S_DONE: begin
        // A held run keeps the result; only a low run re-arms the block.
        if (!run) begin
          w_valid_nxt = 1'b0;
          w_dbz_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_signed_divider
// Purpose  : Self-checking bench for booth_signed_divider. Expected results
//            are queued when an operation starts and compared on isValid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_signed_divider;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             run;
  logic             busy;
  logic             isValid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;

  booth_signed_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .run       (run),
    .busy      (busy),
    .isValid   (isValid),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: truncating signed division, remainder takes the
  // dividend's sign, divide-by-zero and the -1 overflow case handled explicitly.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb_;
    sa  = a;
    sb_ = b;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (b == '1) begin
      e.q = -a; e.r = '0; e.dbz = 1'b0;
    end else begin
      e.q = sa / sb_; e.r = sa % sb_; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One division: start, wait (bounded) for isValid, compare against the
  // scoreboard, then either hold run or let isValid fall after one cycle.
  task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit toggle, input bit drop, input int hold);
    exp_t e;
    int   k;
    bit   zero;
    zero     = (b == '0);
    Dividend = a;
    Divisor  = b;
    run      = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    k = 0;
    chk("busy_after_start", {31'd0, busy}, zero ? 32'd0 : 32'd1);
    while (!isValid && k < WIDTH + 8) begin
      if (toggle && k == 3) begin
        Dividend = $urandom;
        Divisor  = $urandom;
      end
      if (drop && k == 5) run = 1'b0;
      @(posedge clk); #1;
      k++;
      if (!zero && k == WIDTH) chk("busy_in_fix", {31'd0, busy}, 32'd1);
    end
    chk("latency", k, zero ? 32'd0 : 32'(WIDTH + 1));
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("quotient",  quotient,  e.q);
    chk("remainder", remainder, e.r);
    chk("divByZero", {31'd0, divByZero}, {31'd0, e.dbz});
    chk("busy_done", {31'd0, busy}, 32'd0);
    if (drop) begin
      @(posedge clk); #1;
      chk("valid_one_cycle", {31'd0, isValid}, 32'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, isValid}, 32'd1);
        chk("hold_busy",  {31'd0, busy}, 32'd0);
      end
      run = 1'b0;
      @(posedge clk); #1;
      chk("valid_cleared", {31'd0, isValid}, 32'd0);
      chk("dbz_cleared",   {31'd0, divByZero}, 32'd0);
      chk("quot_retained", quotient, e.q);
    end
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    run      = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, isValid}, 32'd0);
    chk("rst_quot",  quotient, 32'd0);
    chk("rst_rem",   remainder, 32'd0);
    chk("rst_dbz",   {31'd0, divByZero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic signed cases
    do_div(32'd28, -32'sd5, 1'b0, 1'b0, 0);
    chk("q_28_m5_const", quotient, 32'hFFFF_FFFB);
    do_div(-32'sd7, 32'd2, 1'b0, 1'b0, 0);
    chk("q_m7_2_const", quotient, 32'hFFFF_FFFD);
    do_div(32'd4, -32'sd7, 1'b0, 1'b0, 0);
    do_div(-32'sd100, -32'sd9, 1'b0, 1'b0, 0);

    // Divide by zero
    do_div(32'd100, 32'd0, 1'b0, 1'b0, 0);

    // Extremes
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    chk("q_overflow_const", quotient, 32'h8000_0000);
    do_div(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    do_div(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 0);
    do_div(32'h8000_0000, 32'd7, 1'b0, 1'b0, 0);

    // Handshake: hold 400 ns, rerun 9/3, operand toggling, run dropped mid-op
    do_div(32'd1234, -32'sd17, 1'b0, 1'b0, 40);
    do_div(32'd9, 32'd3, 1'b0, 1'b0, 0);
    do_div(-32'sd5000, 32'd33, 1'b1, 1'b0, 0);
    do_div(32'd77, 32'd10, 1'b0, 1'b1, 0);

    // Asynchronous reset in the middle of an operation
    Dividend = 32'd28;
    Divisor  = -32'sd5;
    run      = 1'b1;
    sb.push_back(model(Dividend, Divisor));
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, isValid}, 32'd0);
    chk("arst_quot",  quotient, 32'd0);
    chk("arst_rem",   remainder, 32'd0);
    chk("arst_dbz",   {31'd0, divByZero}, 32'd0);
    void'(sb.pop_back());
    run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle_valid", {31'd0, isValid}, 32'd0);
    do_div(32'd28, -32'sd5, 1'b0, 1'b0, 0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
